// File: rtl/au_addsub_arbiter.sv
// Round-robin arbiter sharing one adder-subtractor among NREQ requesters, with a tagged result register.
// Optional carry/borrow output port res_co is enabled by defining AU_ADDSUB_ARB_FLAGS_EN.

module au_addsub #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    // Subtraction is a + ~b + 1; co is the raw carry out of that sum.
    logic [WIDTH-1:0] bx;
    assign bx = b ^ {WIDTH{add_sub}};

    generate
        if (ARCH == 1) begin : g_ripple
            logic [WIDTH:0] c;
            always_comb begin
                c    = '0;
                s    = '0;
                c[0] = add_sub;
                for (int i = 0; i < WIDTH; i++) begin
                    s[i]   = a[i] ^ bx[i] ^ c[i];
                    c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
                end
            end
            assign co = c[WIDTH];
        end else if (ARCH == 2) begin : g_lookahead
            logic [WIDTH-1:0] g;
            logic [WIDTH-1:0] p;
            logic [WIDTH:0]   c;
            logic             pp;
            assign g = a & bx;
            assign p = a ^ bx;
            // Each carry is expanded directly from generate/propagate terms instead of chained.
            always_comb begin
                c    = '0;
                pp   = 1'b0;
                c[0] = add_sub;
                for (int i = 0; i < WIDTH; i++) begin
                    pp = 1'b1;
                    for (int j = i; j >= 0; j--) begin
                        c[i+1] = c[i+1] | (g[j] & pp);
                        pp     = pp & p[j];
                    end
                    c[i+1] = c[i+1] | (pp & add_sub);
                end
            end
            assign s  = p ^ c[WIDTH-1:0];
            assign co = c[WIDTH];
        end else begin : g_behav
            logic [WIDTH:0] sum;
            assign sum = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(add_sub);
            assign s   = sum[WIDTH-1:0];
            assign co  = sum[WIDTH];
        end
    endgenerate
endmodule

module au_addsub_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int ARCH  = 0,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_op,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_s,
    output logic [IDW-1:0]        res_id
`ifdef AU_ADDSUB_ARB_FLAGS_EN
    ,
    output logic                  res_co
`endif
);
    generate
        if (WIDTH < 1 || NREQ < 1 || NREQ > 8 || ARCH < 0 || ARCH > 2) begin : g_bad_param
            $fatal(1, "au_addsub_arbiter: illegal parameters (WIDTH>=1, NREQ 1..8, ARCH 0..2)");
        end
    endgenerate

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_s_q, res_s_d;
    logic [IDW-1:0]   res_id_q, res_id_d;

    logic             load;
    logic             any_gnt;
    logic             xfer;
    logic [IDW-1:0]   gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             op_sel;
    logic [WIDTH-1:0] sum;
    logic             raw_co;

    assign load = ~res_valid_q | res_ready;

    // Search starts at ptr and wraps, so the most recently served port is visited last.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_gnt && req_valid[idx]) begin
                any_gnt = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        gnt[gnt_idx] = any_gnt;
    end

    // rst_n gates ready so no requester sees a handshake while the arbiter is held in reset.
    assign req_ready = gnt & {NREQ{load & rst_n}};
    assign xfer      = load & any_gnt;

    assign a_sel  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign b_sel  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    assign op_sel = req_op[gnt_idx];

    au_addsub #(.WIDTH(WIDTH), .ARCH(ARCH)) u_addsub (
        .a       (a_sel),
        .b       (b_sel),
        .add_sub (op_sel),
        .s       (sum),
        .co      (raw_co)
    );

    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_s_d     = res_s_q;
        res_id_d    = res_id_q;
        if (xfer) begin
            res_valid_d = 1'b1;
            res_s_d     = sum;
            res_id_d    = gnt_idx;
            if (int'(gnt_idx) == NREQ - 1) ptr_d = '0;
            else                           ptr_d = gnt_idx + 1'b1;
        end else if (load) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_s_q     <= '0;
            res_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_s_q     <= res_s_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_s     = res_s_q;
    assign res_id    = res_id_q;

`ifdef AU_ADDSUB_ARB_FLAGS_EN
    // The adder reports carry for a + ~b + 1, which is the inverse of the borrow.
    logic res_co_q, res_co_d;

    always_comb begin
        res_co_d = res_co_q;
        if (xfer) res_co_d = op_sel ? ~raw_co : raw_co;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_co_q <= 1'b0;
        else        res_co_q <= res_co_d;
    end

    assign res_co = res_co_q;
`else
    logic unused_raw_co;
    assign unused_raw_co = raw_co;
`endif
endmodule
